// File: rtl/pulse_peak_detector.sv
// rtl/pulse_peak_detector.sv - threshold pulse detector reporting peak amplitude, time and width
//
// Purpose:
//   Watches a registered ADC sample stream. A pulse starts when the sample rises
//   strictly above threshold (only while enable is high) and ends on the first
//   sample at or below threshold. For each pulse the maximum sample, the timestamp
//   of its first occurrence and the saturating count of above-threshold samples
//   are offered on a valid/ready result port. After each pulse a dead time of
//   HOLDOFF cycles ignores the input.
//
// Ports:
//   clk         - single rising-edge clock
//   reset       - asynchronous, active-low reset
//   input_data  - unsigned ADC sample, one per clk
//   threshold   - unsigned trigger level, compared live every cycle
//   enable      - gates pulse start only
//   peak_valid  - result available
//   peak_ready  - consumer accepts result
//   peak_amp    - pulse maximum
//   peak_time   - timestamp of the maximum
//   peak_width  - samples above threshold, saturating at 255
//   overflow    - sticky, a result was dropped while the previous one was pending
//   busy        - detector is not idle

module pulse_peak_detector #(
  parameter int DATA_W  = 12,
  parameter int TIME_W  = 16,
  parameter int HOLDOFF = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic              enable,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [DATA_W-1:0] peak_amp,
  output logic [TIME_W-1:0] peak_time,
  output logic [7:0]        peak_width,
  output logic              overflow,
  output logic              busy
);

  // Counter wide enough for HOLDOFF-1 and never zero-width, even when HOLDOFF is 0.
  localparam int HOLD_W = $clog2(HOLDOFF + 2);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABOVE,
    ST_HOLD
  } state_t;

  state_t              r_state;
  logic [TIME_W-1:0]   r_time_cnt;
  logic [DATA_W-1:0]   r_sample_q;
  logic [TIME_W-1:0]   r_time_q;
  logic [DATA_W-1:0]   r_max;
  logic [TIME_W-1:0]   r_max_t;
  logic [7:0]          r_width;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_peak_valid;
  logic [DATA_W-1:0]   r_peak_amp;
  logic [TIME_W-1:0]   r_peak_time;
  logic [7:0]          r_peak_width;
  logic                r_overflow;

  logic w_above;
  logic w_commit;
  logic w_xfer;
  logic w_load;

  assign w_above  = r_sample_q > threshold;
  // The pulse ends in the cycle the registered sample drops back to or below threshold.
  assign w_commit = (r_state == ST_ABOVE) && !w_above;
  assign w_xfer   = r_peak_valid && peak_ready;
  // A new result may replace the held one only if the slot is empty or is being emptied now.
  assign w_load   = w_commit && (!r_peak_valid || w_xfer);

  // Input register with timestamp tag; the tag is the counter value before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_time_cnt <= '0;
      r_sample_q <= '0;
      r_time_q   <= '0;
    end else begin
      r_time_cnt <= r_time_cnt + TIME_W'(1);
      r_sample_q <= input_data;
      r_time_q   <= r_time_cnt;
    end
  end

  // Pulse tracking FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_max      <= '0;
      r_max_t    <= '0;
      r_width    <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && w_above) begin
            r_state <= ST_ABOVE;
            r_max   <= r_sample_q;
            r_max_t <= r_time_q;
            r_width <= 8'd1;
          end
        end
        ST_ABOVE: begin
          if (w_above) begin
            if (r_width != 8'hFF) begin
              r_width <= r_width + 8'd1;
            end
            // Strict compare keeps the first occurrence on ties.
            if (r_sample_q > r_max) begin
              r_max   <= r_sample_q;
              r_max_t <= r_time_q;
            end
          end else if (HOLDOFF > 0) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= HOLD_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Result slot and handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_peak_valid <= 1'b0;
      r_peak_amp   <= '0;
      r_peak_time  <= '0;
      r_peak_width <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_peak_valid <= 1'b1;
        r_peak_amp   <= r_max;
        r_peak_time  <= r_max_t;
        r_peak_width <= r_width;
      end else if (w_xfer) begin
        r_peak_valid <= 1'b0;
      end
      if (w_commit && !w_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign peak_valid = r_peak_valid;
  assign peak_amp   = r_peak_amp;
  assign peak_time  = r_peak_time;
  assign peak_width = r_peak_width;
  assign overflow   = r_overflow;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/pulse_peak_detector.md
PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 12, sample width; equals SIZE_ADC_DATA.
- TIME_W, 16, timestamp counter width.
- HOLDOFF, 8, dead-time cycles after a pulse ends; 0 means no dead time.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is rising-edge.
- reset, in, 1, asynchronous, active-low.
- input_data, in, DATA_W, unsigned ADC sample, one per clk (exp_sig_gen/filter stream).
- threshold, in, DATA_W, unsigned trigger level; used live every cycle.
- enable, in, 1, gates pulse start only.
- peak_valid, out, 1, result available.
- peak_ready, in, 1, consumer accepts result.
- peak_amp, out, DATA_W, pulse maximum.
- peak_time, out, TIME_W, timestamp of the maximum.
- peak_width, out, 8, samples above threshold, saturating.
- overflow, out, 1, sticky: a result was dropped.
- busy, out, 1, high when the FSM is not IDLE.

Function
REQ-003 Input register: input_data is captured into sample_q every clk, and the current time_cnt value is captured into time_q alongside it.
REQ-004 time_cnt: free-running TIME_W counter, +1 every clk, wraps 2^TIME_W-1 -> 0 with no flag.
REQ-005 Compare rule: "above" means sample_q > threshold, unsigned, strict.
REQ-006 FSM states: IDLE, ABOVE, HOLD. busy = (state != IDLE).
REQ-007 IDLE -> ABOVE when enable=1 and above. On entry: max<=sample_q, max_t<=time_q, width<=1.
REQ-008 While in ABOVE and above:
- width increments, saturating at 255.
- if sample_q > max (strict), max and max_t update; on ties the first maximum wins.
REQ-009 In ABOVE, not above: end of pulse; commit result (REQ-011).
- Next state is HOLD if HOLDOFF>0, else IDLE.
REQ-010 HOLD lasts exactly HOLDOFF cycles, ignores all samples, then goes to IDLE.
REQ-011 Commit:
- If peak_valid=0, or peak_valid&peak_ready in the commit cycle, load peak_amp/peak_time/peak_width and set peak_valid=1 at the next edge.
- Otherwise drop the result and set overflow=1.
REQ-012 Latency: peak_valid rises 2 clk edges after the first sub-threshold sample is presented on input_data.
REQ-013 Handshake:
- A transfer occurs on an edge where peak_valid&peak_ready.
- peak_valid clears after the transfer unless a new commit occurs in the same cycle; in that case it stays 1 with the new data.
- Outputs are stable while peak_valid&!peak_ready.
REQ-014 enable=0 during ABOVE does not abort; the pulse completes normally.
REQ-015 threshold changes take effect on the next compare, including mid-pulse.
REQ-016 overflow is cleared only by reset.

Reset
REQ-017 Reset assertion immediately forces the following, regardless of clk:
- state=IDLE.
- time_cnt=0, sample_q=0, time_q=0.
- peak_valid=0, peak_amp=0, peak_time=0, peak_width=0.
- overflow=0, busy=0.
REQ-018 Reset mid-pulse discards the partial result; no peak_valid follows reset release until a new pulse completes.
REQ-019 The first time_cnt increment occurs on the first clk edge after reset deasserts.

Verification
REQ-020 Basic pulse: threshold=100, ready=1, input 0,0,150,300,200,50 -> one result: amp=300, width=3, peak_time = tag of the 300 sample, peak_valid high for 1 cycle, 2 edges after 50 is presented.
REQ-021 Tie: input 200,250,250,90, threshold=100 -> amp=250, peak_time = tag of the first 250.
REQ-022 Backpressure: ready=0, two pulses spaced beyond HOLDOFF -> first result held stable, second dropped, overflow=1; raising ready then transfers the first result only.
REQ-023 Holdoff: HOLDOFF=8, re-crossing 3 cycles after pulse end -> ignored, no result; re-crossing 10 cycles after -> detected.
REQ-024 Reset mid-pulse: reset low during ABOVE -> all outputs 0 at once; no result after release; time_cnt restarts at 0.
REQ-025 Saturation: 300 consecutive samples at 500 with threshold=100 -> width=255, amp=500, peak_time = tag of the first 500.
